// File: rtl/dmem_wide_bridge_pkg.sv
// Shared types for the 128-bit CPU to 32-bit SRAM data-memory bridge.
// Holds the bus widths, beat geometry, FSM state encoding and beat-slice helper.
package dmem_bridge_pkg;

    localparam int ADDR_W = 8;
    localparam int WORD_W = 128;
    localparam int SRAM_W = 32;
    localparam int BEATS  = WORD_W / SRAM_W;
    localparam int BEAT_W = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RDLAST,
        RESP
    } state_t;

    typedef logic [BEAT_W-1:0] beat_t;

    // Beat 0 is the leftmost (most significant) SRAM word of the CPU word.
    function automatic logic [SRAM_W-1:0] beat_slice(input logic [0:WORD_W-1] word,
                                                      input beat_t            beat);
        return word[SRAM_W*int'(beat) +: SRAM_W];
    endfunction

endpackage

// File: rtl/dmem_wide_bridge_if.sv
// CPU data-memory port plus SRAM macro port of the wide bridge, bundled as one interface.
// slave = bridge view; master = the CPU/SRAM environment around it.
interface dmem_wide_bridge_if;
    import dmem_bridge_pkg::*;

    logic                memEn;
    logic                memWrEn;
    logic [0:ADDR_W-1]   memAddr;
    logic [0:WORD_W-1]   wrData;
    logic [0:WORD_W-1]   rdData;
    logic                memRdy;

    logic                sramEn;
    logic                sramWrEn;
    logic [ADDR_W+1:0]   sramAddr;
    logic [SRAM_W-1:0]   sramWData;
    logic [SRAM_W-1:0]   sramRData;

    modport slave (
        input  memEn, memWrEn, memAddr, wrData, sramRData,
        output rdData, memRdy, sramEn, sramWrEn, sramAddr, sramWData
    );

    modport master (
        output memEn, memWrEn, memAddr, wrData, sramRData,
        input  rdData, memRdy, sramEn, sramWrEn, sramAddr, sramWData
    );

endinterface

// File: rtl/dmem_wide_bridge.sv
// Serves 128-bit CPU accesses from a 32-bit 1-cycle-read SRAM in 4 beats; memRdy pulses 4 (write) / 5 (read) cycles after accept.
// No backpressure: the CPU holds its request until memRdy, requests seen while busy are ignored.
module dmem_wide_bridge
    import dmem_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    dmem_wide_bridge_if.slave bus
);

    state_t                   state;
    state_t                   state_nxt;
    beat_t                    beat;
    logic                     last_beat;
    logic [0:ADDR_W-1]        addr_q;
    logic [0:WORD_W-1]        wr_q;
    logic [0:WORD_W-SRAM_W-1] rd_buf;
    logic [0:WORD_W-1]        rd_q;

    logic                     sram_en;
    logic                     sram_wr_en;
    logic [ADDR_W+1:0]        sram_addr;
    logic [SRAM_W-1:0]        sram_wdata;
    logic                     mem_rdy;

    assign last_beat = (beat == beat_t'(BEATS-1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.memEn) state_nxt = bus.memWrEn ? WR : RD;
            WR:      if (last_beat) state_nxt = RESP;
            RD:      if (last_beat) state_nxt = RDLAST;
            RDLAST:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // SRAM read data lags its address by one edge, so issuing beat k captures beat k-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat   <= '0;
            addr_q <= '0;
            wr_q   <= '0;
            rd_buf <= '0;
            rd_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.memEn) begin
                        addr_q <= bus.memAddr;
                        wr_q   <= bus.wrData;
                        beat   <= '0;
                    end
                end
                WR: begin
                    beat <= beat + 1'b1;
                end
                RD: begin
                    beat <= beat + 1'b1;
                    if (beat != '0) begin
                        rd_buf[SRAM_W*(int'(beat)-1) +: SRAM_W] <= bus.sramRData;
                    end
                end
                RDLAST: begin
                    rd_q <= {rd_buf, bus.sramRData};
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        sram_en    = 1'b0;
        sram_wr_en = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        mem_rdy    = 1'b0;
        case (state)
            WR: begin
                sram_en    = 1'b1;
                sram_wr_en = 1'b1;
                sram_addr  = {addr_q, beat};
                sram_wdata = beat_slice(wr_q, beat);
            end
            RD: begin
                sram_en    = 1'b1;
                sram_addr  = {addr_q, beat};
            end
            RESP: begin
                mem_rdy    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.sramEn    = sram_en;
    assign bus.sramWrEn  = sram_wr_en;
    assign bus.sramAddr  = sram_addr;
    assign bus.sramWData = sram_wdata;
    assign bus.memRdy    = mem_rdy;
    assign bus.rdData    = rd_q;

endmodule

// File: tb/tb_dmem_wide_bridge.sv
// Bench for dmem_wide_bridge: 1024x32 registered-read SRAM model, word-level reference memory,
// and a scoreboard monitor that checks every memRdy against queued expectations.
module tb_dmem_wide_bridge;
    import dmem_bridge_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    dmem_wide_bridge_if bus ();

    dmem_wide_bridge dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // sram_1rw_model behaviour: 1024x32, write or registered read on enabled edges
    logic [31:0] mem [0:1023];
    logic [31:0] rdq = '0;
    int          acc_cnt [0:1023];

    function automatic logic [31:0] seed_word(input int a);
        return 32'hC0DE_0000 ^ 32'(a * 40503);
    endfunction

    initial begin
        for (int a = 0; a < 1024; a++) begin
            mem[a]     = seed_word(a);
            acc_cnt[a] = 0;
        end
    end

    always @(posedge clk) begin
        if (bus.sramEn) begin
            acc_cnt[bus.sramAddr] <= acc_cnt[bus.sramAddr] + 1;
            if (bus.sramWrEn) mem[bus.sramAddr] <= bus.sramWData;
            else              rdq <= mem[bus.sramAddr];
        end
    end
    assign bus.sramRData = rdq;

    // Reference: each CPU word is four SRAM words at addr*4+k, most significant first
    logic [31:0] ref_mem [0:1023];

    typedef struct {
        logic         we;
        logic [127:0] data;
        int           rdy_cyc;
    } exp_t;

    typedef struct {
        logic         we;
        logic [7:0]   a;
        logic [127:0] d;
    } op_t;

    exp_t         expq[$];
    op_t          ops[$];
    int           checks = 0;
    int           errors = 0;
    logic [127:0] last_rd = '0;

    function automatic logic [127:0] ref_read(input logic [7:0] a);
        logic [127:0] r = '0;
        for (int k = 0; k < 4; k++) r = (r << 32) | 128'(ref_mem[int'(a)*4 + k]);
        return r;
    endfunction

    task automatic ref_write(input logic [7:0] a, input logic [127:0] d);
        for (int k = 0; k < 4; k++) ref_mem[int'(a)*4 + k] = d[127 - 32*k -: 32];
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sram_sweep(input string nm);
        int bad = 0;
        int first = -1;
        for (int a = 0; a < 1024; a++) begin
            if (mem[a] !== ref_mem[a]) begin
                bad++;
                if (first < 0) first = a;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d SRAM words differ, first at %h got %h expected %h",
                     nm, bad, first, mem[first], ref_mem[first]);
        end
    endtask

    task automatic issue(input logic we, input logic [7:0] a, input logic [127:0] d, input int acc);
        exp_t e;
        e.we      = we;
        e.rdy_cyc = acc + (we ? 4 : 5);
        if (we) begin
            ref_write(a, d);
            e.data = '0;
        end else begin
            e.data = ref_read(a);
        end
        expq.push_back(e);
        bus.memEn   = 1'b1;
        bus.memWrEn = we;
        bus.memAddr = a;
        bus.wrData  = d;
    endtask

    task automatic wait_rdy();
        int n = 0;
        @(negedge clk);
        while (!bus.memRdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.memRdy) begin
            checks++;
            errors++;
            $display("FAIL rdy_timeout: got no memRdy within 20 cycles expected a pulse");
        end
    endtask

    task automatic single(input logic we, input logic [7:0] a, input logic [127:0] d);
        issue(we, a, d, cyc + 1);
        wait_rdy();
        bus.memEn = 1'b0;
        @(negedge clk);
    endtask

    // memEn stays high across the chain: the next request is accepted in the IDLE after RESP
    task automatic run_chain();
        for (int i = 0; i < ops.size(); i++) begin
            issue(ops[i].we, ops[i].a, ops[i].d, (i == 0) ? cyc + 1 : cyc + 2);
            wait_rdy();
        end
        bus.memEn = 1'b0;
        @(negedge clk);
    endtask

    function automatic int range_hits(input int lo, input int hi);
        int s = 0;
        for (int a = lo; a <= hi; a++) s += acc_cnt[a];
        return s;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by time limit expected end of test");
        $fatal(1);
    end

    initial begin
        logic [31:0]  t1_exp [4];
        logic [127:0] d;
        logic [7:0]   a;
        int           hits_before;

        t1_exp[0] = 32'h00112233;
        t1_exp[1] = 32'h44556677;
        t1_exp[2] = 32'h8899AABB;
        t1_exp[3] = 32'hCCDDEEFF;
        for (int i = 0; i < 1024; i++) ref_mem[i] = seed_word(i);

        reset       = 1'b1;
        bus.memEn   = 1'b0;
        bus.memWrEn = 1'b0;
        bus.memAddr = '0;
        bus.wrData  = '0;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (reset) begin
                    last_rd = '0;
                end else if (bus.memRdy) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_rdy: got memRdy at cycle %0d expected none", cyc);
                    end else begin
                        e = expq.pop_front();
                        chk("rdy_latency", 128'(cyc), 128'(e.rdy_cyc));
                        chk(e.we ? "rddata_hold" : "rddata", bus.rdData, e.we ? last_rd : e.data);
                        if (!e.we) last_rd = e.data;
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {bus.memRdy, bus.sramEn, bus.sramWrEn, bus.sramAddr, bus.sramWData}, '0);
        chk("reset_rddata", bus.rdData, '0);
        reset = 1'b0;
        @(negedge clk);

        // Write 0x05 and check beat order in the SRAM
        single(1'b1, 8'h05, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        for (int k = 0; k < 4; k++) chk("t1_sram_word", 128'(mem[8'h14 + k]), 128'(t1_exp[k]));

        // Read back, then a write must leave rdData alone
        single(1'b0, 8'h05, '0);
        single(1'b1, 8'h33, {4{$urandom}});
        chk("rd_after_wr", bus.rdData, 128'h00112233_44556677_8899AABB_CCDDEEFF);

        // Top address uses 0x3FC..0x3FF, nothing wraps to 0x000
        single(1'b1, 8'hFF, {4{$urandom}});
        single(1'b0, 8'hFF, '0);
        chk("wrap_addr0", 128'(mem[0]), 128'(seed_word(0)));
        sram_sweep("wrap_sram");

        // Busy read: request line toggling to 0x10 must be ignored
        hits_before = range_hits(12'h040, 12'h043);
        issue(1'b0, 8'h05, '0, cyc + 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.memAddr = 8'h10;
            bus.memWrEn = 1'(i);
            bus.memEn   = ~bus.memEn;
        end
        bus.memEn = 1'b0;
        wait_rdy();
        @(negedge clk);
        chk("busy_no_access", 128'(range_hits(12'h040, 12'h043)), 128'(hits_before));

        // Reset after two write beats to 0x07
        d = {4{$urandom}};
        bus.memEn   = 1'b1;
        bus.memWrEn = 1'b1;
        bus.memAddr = 8'h07;
        bus.wrData  = d;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus.memEn = 1'b0;
        #1;
        chk("midrst_ctrl", {bus.memRdy, bus.sramEn, bus.sramWrEn, bus.sramAddr, bus.sramWData}, '0);
        chk("midrst_rddata", bus.rdData, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ref_mem[12'h01C] = d[127:96];
        ref_mem[12'h01D] = d[95:64];
        sram_sweep("midrst_sram");
        single(1'b0, 8'h07, '0);

        // Back-to-back random write/read pairs
        for (int i = 0; i < 16; i++) begin
            op_t o;
            a    = 8'($urandom_range(0, 255));
            o.we = 1'b1;
            o.a  = a;
            o.d  = {4{$urandom}};
            ops.push_back(o);
            o.we = 1'b0;
            o.a  = ($urandom_range(0, 1) == 1) ? a : 8'($urandom_range(0, 255));
            o.d  = '0;
            ops.push_back(o);
        end
        run_chain();
        sram_sweep("random_sram");

        repeat (8) @(negedge clk);
        chk("exp_queue_empty", 128'(expq.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
